conv_fir_mac: RTL and testbench

//  Parametrised successor to the two-operand CONV block: a streaming signed FIR

---
 rtl/conv_fir_mac.sv | 144 ++++++++++++++
 tb/tb_conv_fir_mac.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_fir_mac.sv
// Streaming signed FIR over TAPS coefficients using one shared multiplier.
// Define CONV_SAT_EN to clamp narrow outputs instead of wrapping.
module conv_fir_mac #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     busy
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]         idx_q;

    logic                     accept;
    logic                     coef_ok;
    logic                     last;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [OUT_W-1:0]  res;
    logic                     res_sat;

    assign accept  = in_valid & in_ready;
    assign last    = (idx_q == IDX_W'(TAPS - 1));
    assign busy    = (state_q != S_IDLE);
    assign coef_ok = coef_we && (state_q == S_IDLE) &&
                     ({1'b0, coef_addr} < (IDX_W + 1)'(TAPS));

    assign prod = x_q[idx_q] * c_q[idx_q];
    assign sum  = acc_q + ACC_W'(prod);

    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign res     = OUT_W'(sum);
            assign res_sat = 1'b0;
        end else begin : g_narrow
`ifdef CONV_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX =
                {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN =
                {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
            always_comb begin
                res     = sum[OUT_W-1:0];
                res_sat = 1'b0;
                if (sum > SAT_MAX) begin
                    res     = SAT_MAX[OUT_W-1:0];
                    res_sat = 1'b1;
                end else if (sum < SAT_MIN) begin
                    res     = SAT_MIN[OUT_W-1:0];
                    res_sat = 1'b1;
                end
            end
`else
            logic unused_hi;
            assign unused_hi = ^sum[ACC_W-1:OUT_W];
            assign res       = sum[OUT_W-1:0];
            assign res_sat   = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // held low while reset is asserted
                in_ready = ~reset;
                if (in_valid) state_d = S_MAC;
            end
            S_MAC: begin
                if (last) state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            if (coef_ok) c_q[coef_addr] <= coef_data;
            if (accept) begin
                x_q[0] <= in_data;
                for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
                acc_q <= '0;
                idx_q <= '0;
            end
            if (state_q == S_MAC) begin
                acc_q <= sum;
                idx_q <= idx_q + IDX_W'(1);
                if (last) begin
                    out_data  <= res;
                    out_sat   <= res_sat;
                    out_valid <= 1'b1;
                end
            end
            if (state_q == S_OUT && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_fir_mac.sv
// Scoreboard bench for conv_fir_mac with directed, hand-computed vectors.
// Expected overflow results follow CONV_SAT_EN when it is defined.
module tb_conv_fir_mac;

    logic              clk = 1'b0;
    logic              reset;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic [7:0]        coef_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] out_data;
    logic              out_sat;
    logic              busy;

    typedef struct {
        int d;
        int s;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    conv_fir_mac #(
        .DATA_W(8),
        .COEF_W(8),
        .TAPS  (4),
        .OUT_W (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'(out_data), 99999);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", int'(out_data), e.d);
                chk("out_sat", int'(out_sat), e.s);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wr_coef(input int a, input int v);
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = a[1:0];
        coef_data = v[7:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic send(input int d, input int ed, input int es, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 1, 0);
        if (push) exp_q.push_back('{ed, es});
        in_valid = 1'b1;
        in_data  = d[7:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic latency_chk(input string name);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk(name, int'(out_valid), (k == 4) ? 1 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        reset     = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        // impulse
        wr_coef(0, 1);
        send(-120, -120, 0, 1);
        latency_chk("impulse_latency");
        for (int i = 0; i < 3; i++) send(0, 0, 0, 1);

        // ramp-up
        for (int i = 0; i < 4; i++) wr_coef(i, 55);
        send(-120, -6600, 0, 1);
        send(-120, -13200, 0, 1);
        send(-120, -19800, 0, 1);
        send(-120, -26400, 0, 1);

        // overflow
        for (int i = 0; i < 4; i++) wr_coef(i, -128);
`ifdef CONV_SAT_EN
        send(-128, 32767, 1, 1);
        send(-128, 32767, 1, 1);
        send(-128, 32767, 1, 1);
        send(-128, 32767, 1, 1);
`else
        send(-128, -3072, 0, 1);
        send(-128, -2048, 0, 1);
        send(-128, -1024, 0, 1);
        send(-128, 0, 0, 1);
`endif

        // backpressure
        wr_coef(0, 2);
        wr_coef(1, 0);
        wr_coef(2, 0);
        wr_coef(3, 0);
        out_ready = 1'b0;
        send(100, 200, 0, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        in_valid = 1'b1;
        in_data  = 8'd50;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!out_valid || out_data != 16'sd200 || in_ready) bad++;
        end
        chk("bp_hold_violations", bad, 0);
        exp_q.push_back('{100, 0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", int'(busy), 1);

        // coefficient write while busy is dropped
        wait_idle();
        send(10, 20, 0, 1);
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 8'd7;
        @(posedge clk); #1;
        coef_we = 1'b0;
        send(3, 6, 0, 1);

        // write on the accepting edge is used by that sample
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 8'd5;
        send(4, 20, 0, 1);
        coef_we = 1'b0;
        send(1, 5, 0, 1);

        // reset mid-MAC at idx 2
        wait_idle();
        send(9, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready_low", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("midrst_no_output", bad, 0);
        send(-120, 0, 0, 1);
        latency_chk("postrst_latency");

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
